// File: rtl/btn_pio_irq_if.sv
// Avalon-MM slave bus bundle for btn_pio_irq: word address, select, write strobe,
// registered read data and the level interrupt back to the processor.
interface btn_pio_irq_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/btn_pio_irq.sv
// Debounced input PIO: 2-flop synchronizer, per-bit debounce, sticky edge capture,
// interrupt mask and level IRQ behind a 4-word Avalon-MM register map.
module btn_pio_irq #(
    parameter int               WIDTH           = 4,
    parameter int               DEBOUNCE_CYCLES = 16,
    parameter int               EDGE_TYPE       = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE     = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    btn_pio_irq_if.slave     bus
);
    logic [WIDTH-1:0] sync1_r;
    logic [WIDTH-1:0] sync2_r;
    logic [WIDTH-1:0] stable_r;
    logic [WIDTH-1:0] strobe_s;
    logic [WIDTH-1:0] set_s;
    logic [WIDTH-1:0] clr_s;
    logic [WIDTH-1:0] irqmask_r;
    logic [WIDTH-1:0] edgecap_r;
    logic             wr_s;
    logic [31:0]      rd_next_s;
    logic             unused_s;

    // Two-flop synchronizer for the asynchronous pins
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= RESET_VALUE;
            sync2_r <= RESET_VALUE;
        end else begin
            sync1_r <= in_port;
            sync2_r <= sync1_r;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            // Debounce bypassed: follow the synchronizer directly
            always_ff @(posedge clk) begin
                if (reset) begin
                    stable_r <= RESET_VALUE;
                end else begin
                    stable_r <= sync2_r;
                end
            end

            assign strobe_s = sync2_r ^ stable_r;
        end else begin : g_debounce
            localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0] cnt_r [WIDTH];

            // Per-bit stability counters; a difference must persist to be accepted
            always_ff @(posedge clk) begin
                if (reset) begin
                    stable_r <= RESET_VALUE;
                    for (int i = 0; i < WIDTH; i++) begin
                        cnt_r[i] <= {CW{1'b0}};
                    end
                end else begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (sync2_r[i] == stable_r[i]) begin
                            cnt_r[i] <= {CW{1'b0}};
                        end else if (cnt_r[i] == CNT_LAST) begin
                            stable_r[i] <= sync2_r[i];
                            cnt_r[i]    <= {CW{1'b0}};
                        end else begin
                            cnt_r[i] <= cnt_r[i] + CW'(1);
                        end
                    end
                end
            end

            // Strobe marks the edge on which a bit's stable value changes
            always_comb begin
                strobe_s = {WIDTH{1'b0}};
                for (int i = 0; i < WIDTH; i++) begin
                    strobe_s[i] = (sync2_r[i] != stable_r[i]) && (cnt_r[i] == CNT_LAST);
                end
            end
        end
    endgenerate

    // Edge-type filter; the new stable value equals sync2 whenever strobe is high
    always_comb begin
        set_s = {WIDTH{1'b0}};
        case (EDGE_TYPE)
            32'sd0:  set_s = strobe_s & sync2_r;
            32'sd1:  set_s = strobe_s & ~sync2_r;
            default: set_s = strobe_s;
        endcase
    end

    // Write decode and read mux
    always_comb begin
        wr_s      = bus.chipselect & ~bus.write_n;
        clr_s     = {WIDTH{1'b0}};
        rd_next_s = 32'h0000_0000;
        if (wr_s && (bus.address == 2'd3)) begin
            clr_s = bus.writedata[WIDTH-1:0];
        end else begin
            clr_s = {WIDTH{1'b0}};
        end
        case (bus.address)
            2'd0:    rd_next_s[WIDTH-1:0] = stable_r;
            2'd2:    rd_next_s[WIDTH-1:0] = irqmask_r;
            2'd3:    rd_next_s[WIDTH-1:0] = edgecap_r;
            default: rd_next_s = 32'h0000_0000;
        endcase
    end

    // Mask, sticky capture (set beats clear) and registered read data
    always_ff @(posedge clk) begin
        if (reset) begin
            irqmask_r    <= {WIDTH{1'b0}};
            edgecap_r    <= {WIDTH{1'b0}};
            bus.readdata <= 32'h0000_0000;
        end else begin
            if (wr_s && (bus.address == 2'd2)) begin
                irqmask_r <= bus.writedata[WIDTH-1:0];
            end
            edgecap_r    <= (edgecap_r & ~clr_s) | set_s;
            bus.readdata <= rd_next_s;
        end
    end

    assign bus.irq  = |(edgecap_r & irqmask_r);
    assign unused_s = ^bus.writedata;
endmodule

// File: tb/tb_btn_pio_irq.sv
// Directed bench: table-driven cycle vectors for a 4-bit rising-edge instance, plus
// hand sequences for glitch rejection, set/clear collision and 32-bit debounce bypass.
module tb_btn_pio_irq;
    logic        clk;
    logic        rst;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  pin_a;
    logic [3:0]  pin_b;
    logic [31:0] pin_c;
    int          n_cmp;
    int          n_err;

    btn_pio_irq_if bus_a ();
    btn_pio_irq_if bus_b ();
    btn_pio_irq_if bus_c ();

    assign bus_a.address = address;   assign bus_a.chipselect = chipselect;
    assign bus_a.write_n = write_n;   assign bus_a.writedata  = writedata;
    assign bus_b.address = address;   assign bus_b.chipselect = chipselect;
    assign bus_b.write_n = write_n;   assign bus_b.writedata  = writedata;
    assign bus_c.address = address;   assign bus_c.chipselect = chipselect;
    assign bus_c.write_n = write_n;   assign bus_c.writedata  = writedata;

    btn_pio_irq #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0), .RESET_VALUE(4'h0))
        dut_a (.clk(clk), .reset(rst), .in_port(pin_a), .bus(bus_a));
    btn_pio_irq #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2), .RESET_VALUE(4'h0))
        dut_b (.clk(clk), .reset(rst), .in_port(pin_b), .bus(bus_b));
    btn_pio_irq #(.WIDTH(32), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2), .RESET_VALUE(32'h0))
        dut_c (.clk(clk), .reset(rst), .in_port(pin_c), .bus(bus_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic [3:0]  pin;
        logic [1:0]  addr;
        logic        cs;
        logic        wn;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        irq;
    } vec_t;

    vec_t tbl [41];

    function automatic vec_t v(logic r, logic [3:0] p, logic [1:0] a, logic c, logic w,
                               logic [31:0] d, logic [31:0] erd, logic eirq);
        vec_t x;
        x.rst = r; x.pin = p; x.addr = a; x.cs = c; x.wn = w;
        x.wd = d;  x.rd = erd; x.irq = eirq;
        return x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_idle(logic [1:0] a);
        address    = a;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0000_0000;
    endtask

    task automatic bus_write(logic [1:0] a, logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        pin_a = 4'h0;
        pin_b = 4'h0;
        pin_c = 32'h0;
        bus_idle(2'd0);

        // reset with pins high, then the all-ones change debounces through
        tbl[0]  = v(1'b1, 4'hF, 2'd0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        tbl[1]  = v(1'b1, 4'hF, 2'd0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        tbl[2]  = v(1'b1, 4'hF, 2'd0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        tbl[3]  = v(1'b0, 4'hF, 2'd0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        tbl[4]  = v(1'b0, 4'hF, 2'd3, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        tbl[5]  = v(1'b0, 4'hF, 2'd2, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        tbl[6]  = v(1'b0, 4'hF, 2'd0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        tbl[7]  = v(1'b0, 4'hF, 2'd0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        tbl[8]  = v(1'b0, 4'hF, 2'd0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        tbl[9]  = v(1'b0, 4'hF, 2'd0, 1'b0, 1'b1, 32'h0, 32'hF, 1'b0);
        tbl[10] = v(1'b0, 4'hF, 2'd3, 1'b0, 1'b1, 32'h0, 32'hF, 1'b0);
        // reset with pending edges clears everything
        tbl[11] = v(1'b1, 4'h0, 2'd3, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        tbl[12] = v(1'b1, 4'h0, 2'd3, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        tbl[13] = v(1'b0, 4'h0, 2'd3, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        tbl[14] = v(1'b0, 4'h0, 2'd0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        // mask bit 0, press bit 0: irq after edge 5, not edge 4
        tbl[15] = v(1'b0, 4'h0, 2'd2, 1'b1, 1'b0, 32'h1, 32'h0, 1'b0);
        tbl[16] = v(1'b0, 4'h1, 2'd2, 1'b0, 1'b1, 32'h0, 32'h1, 1'b0);
        tbl[17] = v(1'b0, 4'h1, 2'd0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        tbl[18] = v(1'b0, 4'h1, 2'd0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        tbl[19] = v(1'b0, 4'h1, 2'd0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        tbl[20] = v(1'b0, 4'h1, 2'd0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        tbl[21] = v(1'b0, 4'h1, 2'd0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1);
        tbl[22] = v(1'b0, 4'h1, 2'd0, 1'b0, 1'b1, 32'h0, 32'h1, 1'b1);
        tbl[23] = v(1'b0, 4'h1, 2'd3, 1'b0, 1'b1, 32'h0, 32'h1, 1'b1);
        // clear edge: irq drops on the write edge; release is a falling edge, not captured
        tbl[24] = v(1'b0, 4'h1, 2'd3, 1'b1, 1'b0, 32'h1, 32'h1, 1'b0);
        tbl[25] = v(1'b0, 4'h0, 2'd3, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        tbl[26] = v(1'b0, 4'h0, 2'd3, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        tbl[27] = v(1'b0, 4'h0, 2'd3, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        tbl[28] = v(1'b0, 4'h0, 2'd3, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        tbl[29] = v(1'b0, 4'h0, 2'd3, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        tbl[30] = v(1'b0, 4'h0, 2'd0, 1'b0, 1'b1, 32'h0, 32'h1, 1'b0);
        tbl[31] = v(1'b0, 4'h0, 2'd0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        tbl[32] = v(1'b0, 4'h0, 2'd3, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        // unselected write ignored; data/reserved writes ignored; upper bits read 0
        tbl[33] = v(1'b0, 4'h0, 2'd2, 1'b0, 1'b0, 32'h0, 32'h1, 1'b0);
        tbl[34] = v(1'b0, 4'h0, 2'd2, 1'b0, 1'b1, 32'h0, 32'h1, 1'b0);
        tbl[35] = v(1'b0, 4'h0, 2'd0, 1'b1, 1'b0, 32'hF, 32'h0, 1'b0);
        tbl[36] = v(1'b0, 4'h0, 2'd1, 1'b1, 1'b0, 32'hF, 32'h0, 1'b0);
        tbl[37] = v(1'b0, 4'h0, 2'd0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        tbl[38] = v(1'b0, 4'h0, 2'd2, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h1, 1'b0);
        tbl[39] = v(1'b0, 4'h0, 2'd2, 1'b0, 1'b1, 32'h0, 32'hF, 1'b0);
        tbl[40] = v(1'b0, 4'h0, 2'd1, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);

        for (int i = 0; i < 41; i++) begin
            rst        = tbl[i].rst;
            pin_a      = tbl[i].pin;
            address    = tbl[i].addr;
            chipselect = tbl[i].cs;
            write_n    = tbl[i].wn;
            writedata  = tbl[i].wd;
            tick();
            check($sformatf("a_row%0d_rd", i), bus_a.readdata, tbl[i].rd);
            check($sformatf("a_row%0d_irq", i), {31'h0, bus_a.irq}, {31'h0, tbl[i].irq});
        end

        // glitch on bit 1 of dut_b: three high samples, then low
        rst = 1'b1; bus_idle(2'd0); pin_b = 4'h0;
        tick(); tick();
        rst = 1'b0;
        bus_write(2'd2, 32'hF);
        tick();
        bus_idle(2'd0);
        pin_b = 4'h2;
        tick(); tick(); tick();
        pin_b = 4'h0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("b_glitch_irq%0d", k), {31'h0, bus_b.irq}, 32'h0);
            check($sformatf("b_glitch_data%0d", k), bus_b.readdata, 32'h0);
        end
        address = 2'd3;
        tick();
        check("b_glitch_edgecap", bus_b.readdata, 32'h0);

        // bit 2 strobes on the same edge its capture bit is written to clear
        pin_b = 4'h4;
        tick();
        tick(); tick(); tick(); tick();
        check("b_coll_pre_irq", {31'h0, bus_b.irq}, 32'h0);
        bus_write(2'd3, 32'h4);
        tick();
        check("b_coll_irq", {31'h0, bus_b.irq}, 32'h1);
        bus_idle(2'd3);
        tick();
        check("b_coll_edgecap", bus_b.readdata, 32'h4);
        check("b_coll_irq_hold", {31'h0, bus_b.irq}, 32'h1);

        // 32-bit bypass: readdata shows the pattern three edges after sampling
        rst = 1'b1; bus_idle(2'd0); pin_c = 32'h0;
        tick(); tick();
        rst = 1'b0;
        pin_c = 32'hA5A5_0F0F;
        tick();
        check("c_edge0", bus_c.readdata, 32'h0);
        tick();
        check("c_edge1", bus_c.readdata, 32'h0);
        tick();
        check("c_edge2", bus_c.readdata, 32'h0);
        check("c_edge2_irq", {31'h0, bus_c.irq}, 32'h0);
        tick();
        check("c_edge3", bus_c.readdata, 32'hA5A5_0F0F);
        address = 2'd1;
        tick();
        check("c_reserved", bus_c.readdata, 32'h0);
        address = 2'd3;
        tick();
        check("c_edgecap", bus_c.readdata, 32'hA5A5_0F0F);
        bus_write(2'd2, 32'hFFFF_FFFF);
        tick();
        check("c_irq", {31'h0, bus_c.irq}, 32'h1);
        bus_idle(2'd2);
        tick();
        check("c_mask", bus_c.readdata, 32'hFFFF_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
